// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard for the 5-stage LEGv8 pipeline: tracks in-flight
// destinations through EX/MEM/WB, picks forwarding sources and raises decode stalls.
module hazard_scoreboard #(
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_rn_used,
  input  logic             id_rm_used,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_rn_sel,
  output logic [1:0]       fwd_rm_sel,
  output logic [4:0]       ex_rd,
  output logic [4:0]       mem_rd,
  output logic [4:0]       wb_rd,
  output logic             ex_vld,
  output logic             mem_vld,
  output logic             wb_vld,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [4:0] XZR = 5'd31;

  // Stage index 0 = EX, 1 = MEM, 2 = WB.
  logic [2:0]       vld_reg;
  logic [2:0]       ld_reg;
  logic [2:0][4:0]  rd_reg;
  logic [CNT_W-1:0] stall_count_reg;

  logic [2:0] rn_hit;
  logic [2:0] rm_hit;
  logic       issue;
  logic       ex_vld_next;
  logic [4:0] ex_rd_next;
  logic       ex_ld_next;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_match
      assign rn_hit[gi] = id_rn_used && (id_rn != XZR) && vld_reg[gi] && (rd_reg[gi] == id_rn);
      assign rm_hit[gi] = id_rm_used && (id_rm != XZR) && vld_reg[gi] && (rd_reg[gi] == id_rm);
    end
  endgenerate

  // Youngest producer wins: EX before MEM before WB.
  function automatic logic [1:0] pick_sel(input logic [2:0] hit);
    if (hit[0])      return 2'b01;
    else if (hit[1]) return 2'b10;
    else if (hit[2]) return 2'b11;
    else             return 2'b00;
  endfunction

  always_comb begin
    issue      = id_valid && !flush;
    stall      = 1'b0;
    fwd_rn_sel = 2'b00;
    fwd_rm_sel = 2'b00;
    if (FWD_EN) begin
      stall      = issue && (rn_hit[0] || rm_hit[0]) && ld_reg[0];
      fwd_rn_sel = pick_sel(rn_hit);
      fwd_rm_sel = pick_sel(rm_hit);
    end else begin
      stall = issue && ((|rn_hit) || (|rm_hit));
    end
  end

  // A bubble entering EX carries zeroed rd/ld so debug keys stay clean.
  always_comb begin
    ex_vld_next = id_valid && id_reg_write && (id_rd != XZR) && !stall && !flush;
    ex_rd_next  = ex_vld_next ? id_rd : 5'd0;
    ex_ld_next  = ex_vld_next ? id_is_load : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_reg         <= '0;
      ld_reg          <= '0;
      rd_reg          <= '0;
      stall_count_reg <= '0;
    end else begin
      vld_reg <= {vld_reg[1], vld_reg[0], ex_vld_next};
      ld_reg  <= {ld_reg[1], ld_reg[0], ex_ld_next};
      rd_reg  <= {rd_reg[1], rd_reg[0], ex_rd_next};
      if (stall && (stall_count_reg != {CNT_W{1'b1}})) begin
        stall_count_reg <= stall_count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign ex_vld      = vld_reg[0];
  assign mem_vld     = vld_reg[1];
  assign wb_vld      = vld_reg[2];
  assign ex_rd       = rd_reg[0];
  assign mem_rd      = rd_reg[1];
  assign wb_rd       = rd_reg[2];
  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a forwarding instance and a no-forwarding instance
// share stimulus; per-step expectations come from hand-derived tables plus a queue.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_rn_used, id_rm_used, id_reg_write, id_is_load, flush;
  logic [4:0] id_rn, id_rm, id_rd;

  logic        stall_f, stall_n;
  logic [1:0]  rn_sel_f, rm_sel_f, rn_sel_n, rm_sel_n;
  logic [4:0]  ex_rd_f, mem_rd_f, wb_rd_f, ex_rd_n, mem_rd_n, wb_rd_n;
  logic        ex_vld_f, mem_vld_f, wb_vld_f, ex_vld_n, mem_vld_n, wb_vld_n;
  logic [31:0] cnt_f, cnt_n;

  logic        cur_stall, cur_ex_vld;
  logic [1:0]  cur_rn, cur_rm;
  logic [4:0]  cur_ex_rd;
  logic [31:0] cur_cnt;
  bit          use_n = 1'b0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.FWD_EN(1'b1), .CNT_W(32)) dut_f (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_rn_used(id_rn_used), .id_rm_used(id_rm_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
    .stall(stall_f), .fwd_rn_sel(rn_sel_f), .fwd_rm_sel(rm_sel_f),
    .ex_rd(ex_rd_f), .mem_rd(mem_rd_f), .wb_rd(wb_rd_f),
    .ex_vld(ex_vld_f), .mem_vld(mem_vld_f), .wb_vld(wb_vld_f), .stall_count(cnt_f));

  hazard_scoreboard #(.FWD_EN(1'b0), .CNT_W(32)) dut_n (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_rn_used(id_rn_used), .id_rm_used(id_rm_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
    .stall(stall_n), .fwd_rn_sel(rn_sel_n), .fwd_rm_sel(rm_sel_n),
    .ex_rd(ex_rd_n), .mem_rd(mem_rd_n), .wb_rd(wb_rd_n),
    .ex_vld(ex_vld_n), .mem_vld(mem_vld_n), .wb_vld(wb_vld_n), .stall_count(cnt_n));

  always_comb begin
    cur_stall  = use_n ? stall_n  : stall_f;
    cur_rn     = use_n ? rn_sel_n : rn_sel_f;
    cur_rm     = use_n ? rm_sel_n : rm_sel_f;
    cur_ex_vld = use_n ? ex_vld_n : ex_vld_f;
    cur_ex_rd  = use_n ? ex_rd_n  : ex_rd_f;
    cur_cnt    = use_n ? cnt_n    : cnt_f;
  end

  typedef struct {
    bit rst; bit v; bit [4:0] rn; bit rnu; bit [4:0] rm; bit rmu;
    bit [4:0] rd; bit rw; bit ld; bit fl;
    bit es; bit [1:0] ern; bit [1:0] erm;
  } step_t;

  typedef struct {
    bit ex_vld; bit [4:0] ex_rd; bit [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned mcnt  = 0;

  function automatic step_t mk(input int rst, v, rn, rnu, rm, rmu, rd, rw, ld, fl, es, ern, erm);
    step_t s;
    s.rst = 1'(rst); s.v = 1'(v); s.rn = 5'(rn); s.rnu = 1'(rnu); s.rm = 5'(rm); s.rmu = 1'(rmu);
    s.rd = 5'(rd); s.rw = 1'(rw); s.ld = 1'(ld); s.fl = 1'(fl);
    s.es = 1'(es); s.ern = 2'(ern); s.erm = 2'(erm);
    return s;
  endfunction

  task automatic drive(input step_t s);
    reset = s.rst; id_valid = s.v; id_rn = s.rn; id_rn_used = s.rnu; id_rm = s.rm;
    id_rm_used = s.rmu; id_rd = s.rd; id_reg_write = s.rw; id_is_load = s.ld; flush = s.fl;
  endtask

  // Expected EX entry and stall counter after the coming clock edge.
  task automatic push_exp(input step_t s);
    exp_t e;
    if (s.rst) begin
      mcnt = 0;
      e.ex_vld = 1'b0; e.ex_rd = 5'd0;
    end else begin
      if (s.es) mcnt++;
      e.ex_vld = s.v && s.rw && (s.rd != 5'd31) && !s.es && !s.fl;
      e.ex_rd  = e.ex_vld ? s.rd : 5'd0;
    end
    e.cnt = mcnt;
    q.push_back(e);
  endtask

  task automatic test_reset();
    use_n = 1'b0;
    drive(mk(1,0,0,0,0,0,0,0,0,0,0,0,0));
    repeat (2) @(negedge clk);
    drive(mk(0,1,0,0,0,0,1,1,0,0,0,0,0));
    @(negedge clk);
    drive(mk(1,0,0,0,0,0,0,0,0,0,0,0,0));
    @(negedge clk);
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
    #2;
    tests++; if ({ex_vld_f, mem_vld_f, wb_vld_f} !== 3'b000) begin fails++; $display("FAIL reset vld_f got %b want 000", {ex_vld_f, mem_vld_f, wb_vld_f}); end
    tests++; if ({ex_vld_n, mem_vld_n, wb_vld_n} !== 3'b000) begin fails++; $display("FAIL reset vld_n got %b want 000", {ex_vld_n, mem_vld_n, wb_vld_n}); end
    tests++; if ({stall_f, stall_n} !== 2'b00) begin fails++; $display("FAIL reset stall got %b want 00", {stall_f, stall_n}); end
    tests++; if ({rn_sel_f, rm_sel_f} !== 4'b0000) begin fails++; $display("FAIL reset sel got %b want 0000", {rn_sel_f, rm_sel_f}); end
    tests++; if ({ex_rd_f, mem_rd_f, wb_rd_f} !== 15'd0) begin fails++; $display("FAIL reset rd got %h want 0", {ex_rd_f, mem_rd_f, wb_rd_f}); end
    tests++; if (cnt_f !== 32'd0) begin fails++; $display("FAIL reset stall_count got %0d want 0", cnt_f); end
    $display("[TB] reset: vld=%b stall=%b cnt=%0d", {ex_vld_f, mem_vld_f, wb_vld_f}, stall_f, cnt_f);
    q.delete();
    mcnt = 0;
  endtask

  task automatic test_forward();
    step_t s[$];
    exp_t  e;
    use_n = 1'b0;
    s.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,0));
    s.push_back(mk(0,1,0,0,0,0,1,1,0,0, 0,0,0));  // ADD X1
    s.push_back(mk(0,1,1,1,2,1,4,1,0,0, 0,1,0));  // SUB X4, X1, X2
    s.push_back(mk(0,1,1,1,0,0,0,0,0,0, 0,2,0));
    s.push_back(mk(0,1,1,1,0,0,0,0,0,0, 0,3,0));
    s.push_back(mk(0,1,1,1,0,0,0,0,0,0, 0,0,0));
    s.push_back(mk(0,1,0,0,0,0,6,1,0,0, 0,0,0));  // ADD X6
    s.push_back(mk(0,1,0,0,6,1,6,1,0,0, 0,0,1));  // ADD X6, .., X6
    s.push_back(mk(0,1,6,1,6,1,0,0,0,0, 0,1,1));  // EX and MEM both hold X6
    s.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0));
    foreach (s[i]) begin
      @(negedge clk); drive(s[i]); #2;
      tests++; if (cur_stall !== s[i].es) begin fails++; $display("FAIL forward[%0d] stall got %0b want %0b", i, cur_stall, s[i].es); end
      tests++; if (cur_rn !== s[i].ern) begin fails++; $display("FAIL forward[%0d] fwd_rn_sel got %b want %b", i, cur_rn, s[i].ern); end
      tests++; if (cur_rm !== s[i].erm) begin fails++; $display("FAIL forward[%0d] fwd_rm_sel got %b want %b", i, cur_rm, s[i].erm); end
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++; if (cur_ex_vld !== e.ex_vld || cur_ex_rd !== e.ex_rd) begin fails++; $display("FAIL forward[%0d] ex got vld=%0b rd=%0d want vld=%0b rd=%0d", i, cur_ex_vld, cur_ex_rd, e.ex_vld, e.ex_rd); end
        tests++; if (cur_cnt !== e.cnt) begin fails++; $display("FAIL forward[%0d] stall_count got %0d want %0d", i, cur_cnt, e.cnt); end
      end
      $display("[TB] forward[%0d] stall=%0b rn_sel=%b rm_sel=%b ex_vld=%0b cnt=%0d", i, cur_stall, cur_rn, cur_rm, cur_ex_vld, cur_cnt);
      push_exp(s[i]);
    end
  endtask

  task automatic test_load_use();
    step_t s[$];
    exp_t  e;
    use_n = 1'b0;
    s.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,0));
    s.push_back(mk(0,1,0,0,0,0,3,1,1,0, 0,0,0));   // LDUR X3
    s.push_back(mk(0,1,2,1,3,1,8,1,0,0, 1,0,1));   // ADD X8, X2, X3 -> stall
    s.push_back(mk(0,1,2,1,3,1,8,1,0,0, 0,0,2));   // replay, load now in MEM
    s.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0));
    s.push_back(mk(0,1,0,0,0,0,9,1,1,0, 0,0,0));   // LDUR X9
    s.push_back(mk(0,1,9,1,31,1,0,0,0,0, 1,1,0));  // reader of X9 via Rn
    s.push_back(mk(0,1,9,1,31,1,0,0,0,0, 0,2,0));
    s.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0));
    foreach (s[i]) begin
      @(negedge clk); drive(s[i]); #2;
      tests++; if (cur_stall !== s[i].es) begin fails++; $display("FAIL load_use[%0d] stall got %0b want %0b", i, cur_stall, s[i].es); end
      tests++; if (cur_rn !== s[i].ern) begin fails++; $display("FAIL load_use[%0d] fwd_rn_sel got %b want %b", i, cur_rn, s[i].ern); end
      tests++; if (cur_rm !== s[i].erm) begin fails++; $display("FAIL load_use[%0d] fwd_rm_sel got %b want %b", i, cur_rm, s[i].erm); end
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++; if (cur_ex_vld !== e.ex_vld || cur_ex_rd !== e.ex_rd) begin fails++; $display("FAIL load_use[%0d] ex got vld=%0b rd=%0d want vld=%0b rd=%0d", i, cur_ex_vld, cur_ex_rd, e.ex_vld, e.ex_rd); end
        tests++; if (cur_cnt !== e.cnt) begin fails++; $display("FAIL load_use[%0d] stall_count got %0d want %0d", i, cur_cnt, e.cnt); end
      end
      $display("[TB] load_use[%0d] stall=%0b rn_sel=%b rm_sel=%b ex_vld=%0b cnt=%0d", i, cur_stall, cur_rn, cur_rm, cur_ex_vld, cur_cnt);
      push_exp(s[i]);
    end
  endtask

  task automatic test_xzr();
    step_t s[$];
    exp_t  e;
    use_n = 1'b0;
    s.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,0));
    s.push_back(mk(0,1,0,0,0,0,31,1,0,0, 0,0,0));   // ADD XZR
    s.push_back(mk(0,1,31,1,31,1,0,0,0,0, 0,0,0));
    s.push_back(mk(0,1,0,0,0,0,31,1,1,0, 0,0,0));   // LDUR XZR
    s.push_back(mk(0,1,31,1,31,1,0,0,0,0, 0,0,0));
    s.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0));
    foreach (s[i]) begin
      @(negedge clk); drive(s[i]); #2;
      tests++; if (cur_stall !== s[i].es) begin fails++; $display("FAIL xzr[%0d] stall got %0b want %0b", i, cur_stall, s[i].es); end
      tests++; if (cur_rn !== s[i].ern) begin fails++; $display("FAIL xzr[%0d] fwd_rn_sel got %b want %b", i, cur_rn, s[i].ern); end
      tests++; if (cur_rm !== s[i].erm) begin fails++; $display("FAIL xzr[%0d] fwd_rm_sel got %b want %b", i, cur_rm, s[i].erm); end
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++; if (cur_ex_vld !== e.ex_vld || cur_ex_rd !== e.ex_rd) begin fails++; $display("FAIL xzr[%0d] ex got vld=%0b rd=%0d want vld=%0b rd=%0d", i, cur_ex_vld, cur_ex_rd, e.ex_vld, e.ex_rd); end
        tests++; if (cur_cnt !== e.cnt) begin fails++; $display("FAIL xzr[%0d] stall_count got %0d want %0d", i, cur_cnt, e.cnt); end
      end
      $display("[TB] xzr[%0d] stall=%0b rn_sel=%b rm_sel=%b ex_vld=%0b cnt=%0d", i, cur_stall, cur_rn, cur_rm, cur_ex_vld, cur_cnt);
      push_exp(s[i]);
    end
  endtask

  task automatic test_flush();
    step_t s[$];
    exp_t  e;
    use_n = 1'b0;
    s.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,0));
    s.push_back(mk(0,1,0,0,0,0,5,1,1,0, 0,0,0));    // LDUR X5
    s.push_back(mk(0,1,5,1,0,0,10,1,0,1, 0,1,0));   // dependent reader, flushed
    s.push_back(mk(0,1,0,0,0,0,11,1,0,1, 0,0,0));   // flushed producer
    s.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0));
    foreach (s[i]) begin
      @(negedge clk); drive(s[i]); #2;
      tests++; if (cur_stall !== s[i].es) begin fails++; $display("FAIL flush[%0d] stall got %0b want %0b", i, cur_stall, s[i].es); end
      tests++; if (cur_rn !== s[i].ern) begin fails++; $display("FAIL flush[%0d] fwd_rn_sel got %b want %b", i, cur_rn, s[i].ern); end
      tests++; if (cur_rm !== s[i].erm) begin fails++; $display("FAIL flush[%0d] fwd_rm_sel got %b want %b", i, cur_rm, s[i].erm); end
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++; if (cur_ex_vld !== e.ex_vld || cur_ex_rd !== e.ex_rd) begin fails++; $display("FAIL flush[%0d] ex got vld=%0b rd=%0d want vld=%0b rd=%0d", i, cur_ex_vld, cur_ex_rd, e.ex_vld, e.ex_rd); end
        tests++; if (cur_cnt !== e.cnt) begin fails++; $display("FAIL flush[%0d] stall_count got %0d want %0d", i, cur_cnt, e.cnt); end
      end
      $display("[TB] flush[%0d] stall=%0b rn_sel=%b rm_sel=%b ex_vld=%0b cnt=%0d", i, cur_stall, cur_rn, cur_rm, cur_ex_vld, cur_cnt);
      push_exp(s[i]);
    end
  endtask

  task automatic test_no_fwd();
    step_t s[$];
    exp_t  e;
    use_n = 1'b1;
    q.delete();
    s.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,0));
    s.push_back(mk(0,1,0,0,0,0,7,1,0,0, 0,0,0));    // ADD X7
    s.push_back(mk(0,1,7,1,0,0,12,1,0,0, 1,0,0));   // producer in EX
    s.push_back(mk(0,1,7,1,0,0,12,1,0,0, 1,0,0));   // producer in MEM
    s.push_back(mk(0,1,7,1,0,0,12,1,0,0, 1,0,0));   // producer in WB
    s.push_back(mk(0,1,7,1,0,0,12,1,0,0, 0,0,0));   // producer retired
    s.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0));
    s.push_back(mk(0,1,0,0,0,0,7,1,0,0, 0,0,0));    // ADD X7 again
    s.push_back(mk(0,1,7,1,0,0,12,1,0,0, 1,0,0));   // first stall cycle
    s.push_back(mk(1,1,7,1,0,0,12,1,0,0, 1,0,0));   // reset during second stall cycle
    s.push_back(mk(0,1,7,1,0,0,12,1,0,0, 0,0,0));
    s.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0));
    foreach (s[i]) begin
      @(negedge clk); drive(s[i]); #2;
      tests++; if (cur_stall !== s[i].es) begin fails++; $display("FAIL no_fwd[%0d] stall got %0b want %0b", i, cur_stall, s[i].es); end
      tests++; if (cur_rn !== s[i].ern) begin fails++; $display("FAIL no_fwd[%0d] fwd_rn_sel got %b want %b", i, cur_rn, s[i].ern); end
      tests++; if (cur_rm !== s[i].erm) begin fails++; $display("FAIL no_fwd[%0d] fwd_rm_sel got %b want %b", i, cur_rm, s[i].erm); end
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++; if (cur_ex_vld !== e.ex_vld || cur_ex_rd !== e.ex_rd) begin fails++; $display("FAIL no_fwd[%0d] ex got vld=%0b rd=%0d want vld=%0b rd=%0d", i, cur_ex_vld, cur_ex_rd, e.ex_vld, e.ex_rd); end
        tests++; if (cur_cnt !== e.cnt) begin fails++; $display("FAIL no_fwd[%0d] stall_count got %0d want %0d", i, cur_cnt, e.cnt); end
      end
      $display("[TB] no_fwd[%0d] stall=%0b rn_sel=%b rm_sel=%b ex_vld=%0b cnt=%0d", i, cur_stall, cur_rn, cur_rm, cur_ex_vld, cur_cnt);
      push_exp(s[i]);
    end
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_rn = '0; id_rm = '0; id_rn_used = 1'b0;
    id_rm_used = 1'b0; id_rd = '0; id_reg_write = 1'b0; id_is_load = 1'b0; flush = 1'b0;
    test_reset();
    test_forward();
    test_load_use();
    test_xzr();
    test_flush();
    test_no_fwd();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Decode-stage hazard and producer-tracking unit for the 5-stage 64-bit LEGv8 pipeline.
- Write/producer side of operand forwarding: records every in-flight destination register as instructions leave decode and ages it through EX, MEM and WB.
- Tells decode, per source operand, which stage holds the youngest producer.
- Stalls decode on load-use hazards, or on any hazard when forwarding is disabled.

Parameters:
FWD_EN, 1, 1: forward from EX/MEM/WB and stall only on load-use; 0: stall on any pending match.
CNT_W, 32, width of the saturating stall counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
id_valid  input  1  decode holds a real instruction
id_rn  input  5  source register Rn
id_rm  input  5  source register Rm
id_rn_used  input  1  instruction reads Rn
id_rm_used  input  1  instruction reads Rm
id_rd  input  5  destination register
id_reg_write  input  1  instruction writes Rd
id_is_load  input  1  instruction is LDUR (result available after MEM)
flush  input  1  branch taken; squash decode instruction
stall  output  1  hold PC and IF/ID, insert bubble into EX
fwd_rn_sel  output  2  00 regfile, 01 EX producer, 10 MEM producer, 11 WB producer
fwd_rm_sel  output  2  same encoding for Rm
ex_rd, mem_rd, wb_rd  output  5 each  tracked destination per stage (debug/forward mux keys)
ex_vld, mem_vld, wb_vld  output  1 each  entry valid
stall_count  output  CNT_W  cycles with stall=1, saturating

Behaviour:
- State per stage S in {EX, MEM, WB}: vld, rd[4:0], ld.
- Reset (synchronous, active-high):
  - All vld=0, rd=0, ld=0, stall_count=0.
  - Consequently stall=0 and fwd_*_sel=00 in the cycle after reset.
  - Reset asserted mid-stall drops the stall the next cycle.
- Register X31 (XZR) is never tracked and never matched:
  - id_rd==31 enters as a bubble.
  - A source equal to 31 gives sel=00 and causes no stall.
- Match rule: match(src,S) = src_used & src!=31 & S.vld & S.rd==src.
- Forward select (combinational), youngest producer wins:
  - EX match gives 01, else MEM gives 10, else WB gives 11, else 00.
  - Evaluated even when stall=1.
- Stall (combinational), gated by id_valid & !flush:
  - FWD_EN=1: stall = (match(rn,EX) | match(rm,EX)) & EX.ld.
    - A load in MEM forwards with sel=10; no stall.
  - FWD_EN=0: stall = any match in any stage; fwd_*_sel forced to 00.
- Advance, every cycle when not in reset:
  - WB <= MEM, MEM <= EX.
  - EX <= {vld: id_valid & id_reg_write & id_rd!=31 & !stall & !flush, rd: id_rd, ld: id_is_load}.
  - When the new EX entry is not valid, its rd and ld are written as 0.
- Stall and flush together: flush wins.
  - stall output = 0.
  - EX receives a bubble.
- Latency:
  - A load-use pair stalls exactly 1 cycle with FWD_EN=1.
  - With FWD_EN=0, stall lasts until the producer leaves WB: max 3 cycles after the producer enters EX.
- stall_count increments by 1 on each cycle with stall=1 and holds at all-ones.
- Entries wrap out of WB silently; no full or empty conditions exist.

Test Plan:
- Reset, then idle with id_valid=0 -> all vld=0, stall=0, sel=00, stall_count=0.
- ADD X1 (rd=1), then SUB reading rn=1,rm=2 next cycle (FWD_EN=1) -> fwd_rn_sel=01, fwd_rm_sel=00, stall=0; one cycle later a reader of X1 sees 10, then 11, then 00.
- LDUR X3, then ADD reading rm=3 -> stall=1 for exactly 1 cycle, EX gets bubble (ex_vld=0), next cycle fwd_rm_sel=10, stall=0, stall_count=1.
- Producer rd=31 followed by reader rn=31 -> ex_vld=0, sel=00, stall=0.
- LDUR X5 in EX with a dependent reader in decode, flush=1 same cycle -> stall=0, ex_vld=0 next cycle, stall_count unchanged.
- FWD_EN=0: ADD X7 then reader rn=7 -> stall=1 for 3 cycles (producer in EX, MEM, WB), sel=00 throughout, then stall=0, stall_count=3; reset asserted during second stall cycle -> stall=0 and stall_count=0 next cycle.
